// File: rtl/fwd_ctrl.sv
// Forwarding / load-use hazard controller living in ID.
// Keeps a three-deep shadow of destination tags (EX, MEM, WB) and produces
// registered operand-mux selects for the instruction currently in EX.

package Mux3Type;
    // Operand source for the EX-stage operand muxes.
    typedef enum logic [1:0] {
        DEFAULT = 2'd0,  // register file
        LEFT    = 2'd1,  // EX/MEM result
        RIGHT   = 2'd2,  // MEM/WB result
        ZERO    = 2'd3   // constant zero
    } cmd_t;
endpackage

module fwd_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_rd_we,
    input  logic                id_is_load,
    input  logic                hold_i,
    input  logic                flush_i,
    output logic                stall_o,
    output Mux3Type::cmd_t      ex_cmd_a,
    output Mux3Type::cmd_t      ex_cmd_b,
    output logic [CNT_W-1:0]    lu_stall_cnt
);

    // Shadow-pipeline entry describing an in-flight producer.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } tag_t;

    localparam logic [0:0] StRun    = 1'b0;
    localparam logic [0:0] StBubble = 1'b1;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    tag_t            ex_q,  ex_d;
    tag_t            mem_q, mem_d;
    tag_t            wb_q,  wb_d;
    logic [0:0]      state_q, state_d;
    Mux3Type::cmd_t  cmd_a_q, cmd_a_d;
    Mux3Type::cmd_t  cmd_b_q, cmd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    tag_t            id_tag;
    Mux3Type::cmd_t  calc_a;
    Mux3Type::cmd_t  calc_b;
    logic            rs1_ex_hit;
    logic            rs2_ex_hit;
    logic            rs1_mem_hit;
    logic            rs2_mem_hit;
    logic            load_use;
    logic            advance;
    logic            stall_take;

    // A producer feeds a consumer only if it really writes a non-zero register.
    function automatic logic tag_match(input tag_t t, input logic [REG_AW-1:0] rs);
        return t.valid & t.we & (t.rd == rs) & (rs != '0);
    endfunction

    // Per-operand select priority: zero, then youngest producer, then regfile.
    function automatic Mux3Type::cmd_t pick_cmd(input logic used,
                                                input logic [REG_AW-1:0] rs,
                                                input logic ex_hit,
                                                input logic mem_hit);
        Mux3Type::cmd_t c;
        if (!used || rs == '0) begin
            c = Mux3Type::ZERO;
        end else if (ex_hit) begin
            c = Mux3Type::LEFT;
        end else if (mem_hit) begin
            c = Mux3Type::RIGHT;
        end else begin
            // WB needs no path: the regfile writes through to the read port.
            c = Mux3Type::DEFAULT;
        end
        return c;
    endfunction

    assign id_tag = '{valid: 1'b1, rd: id_rd, we: id_rd_we, is_load: id_is_load};

    assign rs1_ex_hit  = tag_match(ex_q,  id_rs1);
    assign rs2_ex_hit  = tag_match(ex_q,  id_rs2);
    assign rs1_mem_hit = tag_match(mem_q, id_rs1);
    assign rs2_mem_hit = tag_match(mem_q, id_rs2);

    // Decode operand selects for the ID instruction against the current shadow tags.
    always_comb begin
        calc_a = pick_cmd(id_rs1_used, id_rs1, rs1_ex_hit, rs1_mem_hit);
        calc_b = pick_cmd(id_rs2_used, id_rs2, rs2_ex_hit, rs2_mem_hit);
    end

    // Load-use: the load result only exists from MEM onwards, so an EX hit must wait.
    assign load_use = ex_q.is_load &
                      ((id_rs1_used & rs1_ex_hit) | (id_rs2_used & rs2_ex_hit));

    // Stall reflects the hazard even under hold; a flush cancels it outright.
    always_comb begin
        stall_o = 1'b0;
        if (state_q == StRun && !flush_i) begin
            stall_o = id_valid & load_use;
        end
    end

    assign advance    = id_valid & ~stall_o & ~hold_i;
    assign stall_take = stall_o & ~hold_i;

    // Next-state for shadow tags, operand selects, FSM and stall counter.
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        cmd_a_d = cmd_a_q;
        cmd_b_d = cmd_b_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            // Flush kills the EX slot even when the rest of the pipe is frozen.
            ex_d    = '0;
            cmd_a_d = Mux3Type::ZERO;
            cmd_b_d = Mux3Type::ZERO;
            state_d = StRun;
            if (!hold_i) begin
                mem_d = ex_q;
                wb_d  = mem_q;
            end
        end else if (!hold_i) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (advance) begin
                ex_d    = id_tag;
                cmd_a_d = calc_a;
                cmd_b_d = calc_b;
            end else begin
                // Either no instruction or a load-use bubble enters EX.
                ex_d    = '0;
                cmd_a_d = Mux3Type::ZERO;
                cmd_b_d = Mux3Type::ZERO;
            end
            if (stall_take) begin
                state_d = StBubble;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntOne;
                end
            end else begin
                state_d = StRun;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            cmd_a_q <= Mux3Type::ZERO;
            cmd_b_q <= Mux3Type::ZERO;
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            cmd_a_q <= cmd_a_d;
            cmd_b_q <= cmd_b_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_cmd_a     = cmd_a_q;
    assign ex_cmd_b     = cmd_b_q;
    assign lu_stall_cnt = cnt_q;

    // WB tag is tracked for completeness; nothing forwards from it.
    logic unused_tags;
    assign unused_tags = ^{wb_q, mem_q.is_load};

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: a per-cycle reference model of the in-flight
// producers plus literal checkpoints for each scenario.

module tb_fwd_ctrl;
    import Mux3Type::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_is_load;
    logic        hold_i;
    logic        flush_i;
    logic        stall_o;
    cmd_t        ex_cmd_a;
    cmd_t        ex_cmd_b;
    logic [31:0] lu_stall_cnt;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 0;

    fwd_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_rd_we     (id_rd_we),
        .id_is_load   (id_is_load),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .ex_cmd_a     (ex_cmd_a),
        .ex_cmd_b     (ex_cmd_b),
        .lu_stall_cnt (lu_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: in-flight producers, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } prod_t;

    prod_t       pipe [3];
    bit          m_bubble;
    cmd_t        m_cmd_a;
    cmd_t        m_cmd_b;
    logic [31:0] m_cnt;

    function automatic bit writes(input prod_t p, input logic [4:0] rs);
        return p.v && p.we && p.rd == rs && rs != 5'd0;
    endfunction

    // Youngest in-flight writer (EX or MEM) decides the source.
    function automatic cmd_t want(input logic used, input logic [4:0] rs);
        if (!used || rs == 5'd0) return ZERO;
        for (int i = 0; i < 2; i++) begin
            if (writes(pipe[i], rs)) return (i == 0) ? LEFT : RIGHT;
        end
        return DEFAULT;
    endfunction

    function automatic bit m_stall();
        bit hz;
        hz = pipe[0].ld && ((id_rs1_used && writes(pipe[0], id_rs1)) ||
                            (id_rs2_used && writes(pipe[0], id_rs2)));
        return !m_bubble && !flush_i && id_valid && hz;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] <= '{v: 0, rd: 0, we: 0, ld: 0};
            m_bubble <= 0;
            m_cmd_a  <= ZERO;
            m_cmd_b  <= ZERO;
            m_cnt    <= 0;
        end else if (flush_i) begin
            pipe[0]  <= '{v: 0, rd: 0, we: 0, ld: 0};
            m_cmd_a  <= ZERO;
            m_cmd_b  <= ZERO;
            m_bubble <= 0;
            if (!hold_i) begin
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
        end else if (!hold_i) begin
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            if (id_valid && !m_stall()) begin
                pipe[0] <= '{v: 1, rd: id_rd, we: id_rd_we, ld: id_is_load};
                m_cmd_a <= want(id_rs1_used, id_rs1);
                m_cmd_b <= want(id_rs2_used, id_rs2);
            end else begin
                pipe[0] <= '{v: 0, rd: 0, we: 0, ld: 0};
                m_cmd_a <= ZERO;
                m_cmd_b <= ZERO;
            end
            m_bubble <= m_stall();
            if (m_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp && rst_n === 1'b1) begin
            check("cyc_stall", {31'd0, stall_o}, {31'd0, m_stall()});
            check("cyc_cmd_a", 32'(ex_cmd_a), 32'(m_cmd_a));
            check("cyc_cmd_b", 32'(ex_cmd_b), 32'(m_cmd_b));
            check("cyc_cnt", lu_stall_cnt, m_cnt);
        end
    end

    // One ID cycle: drive just after the edge, return at the following negedge.
    task automatic drv(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic h, input logic f);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rd       = rd;
        id_rd_we    = we;
        id_is_load  = ld;
        id_rs1      = r1;
        id_rs1_used = u1;
        id_rs2      = r2;
        id_rs2_used = u2;
        hold_i      = h;
        flush_i     = f;
        @(negedge clk);
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_cmds(input string name, input cmd_t a, input cmd_t b);
        check({name, "_a"}, 32'(ex_cmd_a), 32'(a));
        check({name, "_b"}, 32'(ex_cmd_b), 32'(b));
    endtask

    initial begin
        rst_n = 0;
        id_valid = 0; id_rd = 0; id_rd_we = 0; id_is_load = 0;
        id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        hold_i = 0; flush_i = 0;
        repeat (2) @(negedge clk);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        chk_cmds("rst", ZERO, ZERO);
        check("rst_cnt", lu_stall_cnt, 32'd0);
        rst_n   = 1;
        run_cmp = 1;

        // T1: back-to-back dependency on x5.
        drv(1, 5, 1, 0, 1, 1, 2, 1, 0, 0);
        drv(1, 6, 1, 0, 5, 1, 1, 1, 0, 0);
        chk_cmds("t1_first", DEFAULT, DEFAULT);
        nop();
        chk_cmds("t1", LEFT, DEFAULT);
        nop(); nop();

        // T2: distance-two forward, then two writers of x5.
        drv(1, 5, 1, 0, 1, 1, 2, 1, 0, 0);
        nop();
        drv(1, 7, 1, 0, 2, 1, 5, 1, 0, 0);
        nop();
        chk_cmds("t2_mem", DEFAULT, RIGHT);
        drv(1, 5, 1, 0, 1, 1, 2, 1, 0, 0);
        drv(1, 5, 1, 0, 1, 1, 2, 1, 0, 0);
        drv(1, 7, 1, 0, 5, 1, 0, 1, 0, 0);
        nop();
        chk_cmds("t2_young", LEFT, ZERO);
        nop(); nop();

        // T4: x0 source and unused operand despite in-flight x5.
        drv(1, 5, 1, 0, 1, 1, 2, 1, 0, 0);
        drv(1, 0, 1, 0, 1, 1, 2, 1, 0, 0);
        drv(1, 3, 1, 0, 0, 1, 5, 0, 0, 0);
        nop();
        chk_cmds("t4", ZERO, ZERO);
        nop(); nop();

        // T3: load-use with a single bubble.
        drv(1, 8, 1, 1, 1, 1, 0, 0, 0, 0);
        drv(1, 9, 1, 0, 8, 1, 8, 1, 0, 0);
        check("t3_stall", {31'd0, stall_o}, 32'd1);
        drv(1, 9, 1, 0, 8, 1, 8, 1, 0, 0);
        check("t3_release", {31'd0, stall_o}, 32'd0);
        chk_cmds("t3_bubble", ZERO, ZERO);
        nop();
        chk_cmds("t3_fwd", RIGHT, RIGHT);
        check("t3_cnt", lu_stall_cnt, 32'd1);
        nop(); nop();

        // T5: hazard frozen by hold for three cycles, then resumes.
        drv(1, 8, 1, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 9, 1, 0, 8, 1, 8, 1, 1, 0);
            chk_cmds("t5_hold", DEFAULT, ZERO);
            check("t5_hold_cnt", lu_stall_cnt, 32'd1);
        end
        drv(1, 9, 1, 0, 8, 1, 8, 1, 0, 0);
        check("t5_stall", {31'd0, stall_o}, 32'd1);
        drv(1, 9, 1, 0, 8, 1, 8, 1, 0, 0);
        check("t5_release", {31'd0, stall_o}, 32'd0);
        chk_cmds("t5_bubble", ZERO, ZERO);
        nop();
        chk_cmds("t5_fwd", RIGHT, RIGHT);
        check("t5_cnt", lu_stall_cnt, 32'd2);
        nop(); nop();

        // T6: flush in the stall cycle cancels the stall.
        drv(1, 8, 1, 1, 1, 1, 0, 0, 0, 0);
        drv(1, 9, 1, 0, 8, 1, 8, 1, 0, 1);
        check("t6_stall", {31'd0, stall_o}, 32'd0);
        drv(1, 9, 1, 0, 8, 1, 8, 1, 0, 0);
        check("t6_nostall", {31'd0, stall_o}, 32'd0);
        chk_cmds("t6_flushed", ZERO, ZERO);
        nop();
        chk_cmds("t6_fwd", RIGHT, RIGHT);
        check("t6_cnt", lu_stall_cnt, 32'd2);
        nop(); nop();

        // Reset pulse while in the bubble cycle.
        drv(1, 8, 1, 1, 1, 1, 0, 0, 0, 0);
        drv(1, 9, 1, 0, 8, 1, 8, 1, 0, 0);
        check("rp_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk);
        #1;
        check("rp_pre_cnt", lu_stall_cnt, 32'd3);
        rst_n = 0;
        #1;
        check("rp_stall0", {31'd0, stall_o}, 32'd0);
        chk_cmds("rp", ZERO, ZERO);
        check("rp_cnt", lu_stall_cnt, 32'd0);
        #2;
        rst_n = 1;
        drv(1, 5, 1, 0, 1, 1, 2, 1, 0, 0);
        drv(1, 6, 1, 0, 5, 1, 1, 1, 0, 0);
        nop();
        chk_cmds("rp_after", LEFT, DEFAULT);
        nop(); nop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
